// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader
//  Purpose  : Streams DEPTH bytes over a valid/ready handshake into a small
//             program RAM, then optionally reads every word back and compares
//             a modular checksum of what was read against what was written.
//  Revision : 1.0  initial release
// ============================================================================
module ram_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned VERIFY = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ce_n,
  input  logic [DATA_W-1:0] w_bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Address of the final word of a session; with DEPTH == 2**ADDR_W this is
  // all-ones and the counter simply returns to zero afterwards.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WRITE     = 3'd2,
    S_VERIFY_RD = 3'd3,
    S_CHECK     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   wsum_q, wsum_d;
  logic [DATA_W-1:0]   rsum_q, rsum_d;
  logic                error_q, error_d;
  logic                in_ready_q, in_ready_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_ce_n_q, ram_ce_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, datapath and registered-output decode for the load/verify FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    error_d = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new session always restarts from address 0 with clean sums.
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          wsum_d  = '0;
          rsum_d  = '0;
          error_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          wdata_d = in_data;
          wsum_d  = wsum_q + in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = (VERIFY != 0) ? S_VERIFY_RD : S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_VERIFY_RD: begin
        // One word per cycle; the RAM read path is combinational.
        rsum_d = rsum_q + w_bus;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end
      S_CHECK: begin
        error_d = (rsum_q != wsum_q);
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so that they are registered
    // yet line up exactly with the state they describe.
    in_ready_d = (state_d == S_LOAD);
    ram_we_d   = (state_d == S_WRITE);
    ram_ce_n_d = (state_d != S_VERIFY_RD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                 (state_d == S_VERIFY_RD) || (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
  end

  // State, datapath and output registers; reset aborts any session at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_ce_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
      ram_we_q   <= ram_we_d;
      ram_ce_n_q <= ram_ce_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_loader
//  Purpose  : Scoreboard bench for ram_loader: a 16-word loader with readback
//             against a RAM model, plus a DEPTH=1 / no-verify instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_loader;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance: DEPTH=16, VERIFY=1 ----------------
  logic       start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ram_we, ram_ce_n, busy, done, error;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, w_bus;

  ram_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .VERIFY(1)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ce_n(ram_ce_n),
    .w_bus(w_bus), .busy(busy), .done(done), .error(error)
  );

  // RAM model with an optional bit-0 fault on readback of address 6
  logic [7:0] mem [16];
  logic       flip_en = 1'b0;
  always_comb begin
    w_bus = 8'h00;
    if (!ram_ce_n) begin
      w_bus = mem[ram_addr];
      if (flip_en && ram_addr == 4'd6) w_bus = w_bus ^ 8'h01;
    end
  end
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  // ---------------- second instance: DEPTH=1, VERIFY=0 ----------------
  logic       s1_start = 1'b0, s1_valid = 1'b0;
  logic [7:0] s1_data = 8'h00;
  logic       s1_ready, s1_we, s1_ce_n, s1_busy, s1_done, s1_error;
  logic [3:0] s1_addr;
  logic [7:0] s1_wdata;
  logic [7:0] s1_bus;
  assign s1_bus = 8'h00;

  ram_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(1), .VERIFY(0)) dut1 (
    .clk(clk), .clr_n(clr_n), .start(s1_start), .in_valid(s1_valid),
    .in_data(s1_data), .in_ready(s1_ready), .ram_we(s1_we),
    .ram_addr(s1_addr), .ram_wdata(s1_wdata), .ram_ce_n(s1_ce_n),
    .w_bus(s1_bus), .busy(s1_busy), .done(s1_done), .error(s1_error)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  wr_t        mon_e;
  logic       prev_we = 1'b0;
  int         s1_we_cnt = 0;
  logic [7:0] s1_exp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    errs++;
    $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected writes/reads whenever the DUT presents them
  always @(negedge clk) begin
    if (ram_we && !ram_ce_n) fail("we_ce_overlap", 1, 0);
    if (!clr_n && (ram_we || s1_we)) fail("we_in_reset", 1, 0);
    if (ram_we) begin
      if (prev_we) fail("we_pulse_width", 2, 1);
      if (wr_q.size() == 0) begin
        fail("stale_write", {28'h0, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = wr_q.pop_front();
        check("wr_addr", {28'h0, ram_addr}, {28'h0, mon_e.a});
        check("wr_data", {24'h0, ram_wdata}, {24'h0, mon_e.d});
      end
    end
    prev_we = ram_we;
    if (!ram_ce_n) begin
      if (rd_q.size() == 0) fail("extra_read", {28'h0, ram_addr}, 32'hFFFF_FFFF);
      else check("rd_addr", {28'h0, ram_addr}, {28'h0, rd_q.pop_front()});
    end
    if (!s1_ce_n) fail("s1_ce_n_low", 0, 1);
    if (s1_we) begin
      s1_we_cnt++;
      check("s1_wr_addr", {28'h0, s1_addr}, 0);
      check("s1_wr_data", {24'h0, s1_wdata}, {24'h0, s1_exp});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) rd_q.push_back(4'(i));
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] a, input int gap, output int acc);
    int budget;
    budget = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    wr_q.push_back('{a: a, d: d});
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) fail("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(output int n);
    int b;
    b = 0;
    while (!done && b < 200) begin
      @(negedge clk);
      b++;
    end
    n = cyc - t0;
    check("done_seen", {31'h0, done}, 1);
    check("busy_at_done", {31'h0, busy}, 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 0);
    check({tag, "_ram_we"}, {31'h0, ram_we}, 0);
    check({tag, "_ram_ce_n"}, {31'h0, ram_ce_n}, 1);
    check({tag, "_ram_addr"}, {28'h0, ram_addr}, 0);
    check({tag, "_ram_wdata"}, {24'h0, ram_wdata}, 0);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    check({tag, "_done"}, {31'h0, done}, 0);
    check({tag, "_error"}, {31'h0, error}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc;
    int n;
    logic [7:0] exp_b;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    clr_n = 1'b1;

    // Continuous stream 0x00..0x0F; checks the documented edge timing
    do_start();
    check("busy_after_start", {31'h0, busy}, 1);
    for (int k = 0; k < 16; k++) begin
      send(8'(k), 4'(k), 0, acc);
      if (k == 0)  check("accept0_edge", acc - t0, 1);
      if (k == 15) check("accept15_edge", acc - t0, 31);
    end
    wait_done(n);
    check("done_edge", n, 49);
    check("t2_error", {31'h0, error}, 0);

    // Gappy source: in_valid idles for 3 cycles before every other byte
    do_start();
    for (int k = 0; k < 16; k++) send(8'hA0 + 8'(k), 4'(k), (k % 2 == 1) ? 3 : 0, acc);
    wait_done(n);
    check("t3_error", {31'h0, error}, 0);
    for (int k = 0; k < 16; k++) begin
      exp_b = 8'hA0 + 8'(k);
      check("t3_mem", {24'h0, mem[k]}, {24'h0, exp_b});
    end

    // Readback fault on address 6 (0x2A read as 0x2B)
    flip_en = 1'b1;
    do_start();
    for (int k = 0; k < 16; k++) send(8'(7 * k), 4'(k), 0, acc);
    wait_done(n);
    check("t4_error", {31'h0, error}, 1);
    check("t4_done", {31'h0, done}, 1);
    flip_en = 1'b0;

    // Next start clears done/error; a start pulse during LOAD is ignored
    do_start();
    check("t5_done_clr", {31'h0, done}, 0);
    check("t5_error_clr", {31'h0, error}, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        @(negedge clk);
        @(negedge clk);
        check("t5_in_load", {31'h0, in_ready}, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send(8'h50 + 8'(k), 4'(k), 0, acc);
    end
    wait_done(n);
    check("t5_error", {31'h0, error}, 0);

    // Abort after byte 5 is written, then reload from address 0
    do_start();
    for (int k = 0; k < 6; k++) send(8'h30 + 8'(k), 4'(k), 0, acc);
    @(posedge clk);
    #4;
    check("t5_byte5_written", wr_q.size(), 0);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    do_start();
    for (int k = 0; k < 16; k++) send(8'hC0 + 8'(k), 4'(k), 0, acc);
    wait_done(n);
    check("t5_restart_edge", n, 49);
    check("t5_restart_error", {31'h0, error}, 0);
    check("t5_mem0", {24'h0, mem[0]}, 32'hC0);

    // DEPTH=1, VERIFY=0 instance: one write, then straight to DONE
    s1_exp = 8'h5A;
    @(negedge clk);
    s1_start = 1'b1;
    @(posedge clk);
    #1;
    s1_start = 1'b0;
    t0 = cyc;
    check("s1_busy", {31'h0, s1_busy}, 1);
    @(negedge clk);
    s1_valid = 1'b1;
    s1_data  = 8'h5A;
    n = 0;
    while (!s1_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    s1_valid = 1'b0;
    n = 0;
    while (!s1_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s1_done_edge", cyc - t0, 2);
    check("s1_done", {31'h0, s1_done}, 1);
    check("s1_busy_end", {31'h0, s1_busy}, 0);
    check("s1_error", {31'h0, s1_error}, 0);
    repeat (3) @(negedge clk);
    check("s1_we_count", s1_we_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
